// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types, geometry defaults and bias sign extension
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } conv2_state_t;

  localparam int WIDTH_DEF  = 12;
  localparam int HEIGHT_DEF = 12;
  localparam int KSIZE_DEF  = 5;

  // Sign-extend the low 'bits' bits of raw to 32 bits; caller truncates to its width.
  function automatic logic [31:0] sext_bias(input logic [31:0] raw, input int bits);
    logic signed [31:0] t;
    t = signed'(raw << (32 - bits));
    return unsigned'(t >>> (32 - bits));
  endfunction

endpackage

// File: rtl/conv2_pos_cnt.sv
// rtl/conv2_pos_cnt.sv - col/row raster position counter with clear and advance
module conv2_pos_cnt #(
  parameter int WIDTH  = 12,
  parameter int HEIGHT = 12,
  parameter int CW     = 4,
  parameter int RW     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          col_wrap,
  output logic          row_last
);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Position registers; clear wins over advance so a start always begins at (0,0).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Raster step: column wraps into the next row, last row wraps back to row 0.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (advance) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Flags describe the current position, independent of advance.
  always_comb begin
    col_wrap = (col_q == CW'(WIDTH - 1));
    row_last = (row_q == RW'(HEIGHT - 1));
    col      = col_q;
    row      = row_q;
  end

endmodule

// File: rtl/conv2_sched.sv
// rtl/conv2_sched.sv - conv2 window sequencer, frame FSM and bias register file
module conv2_sched
  import cnn_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int HEIGHT    = HEIGHT_DEF,
  parameter int KSIZE     = KSIZE_DEF,
  parameter int DATA_BITS = 12,
  parameter int BIAS_BITS = 8,
  parameter int CHANNELS  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 valid_in,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_addr,
  input  logic [BIAS_BITS-1:0] cfg_wdata,
  output logic                 win_valid,
  output logic [DATA_BITS-1:0] bias_0,
  output logic [DATA_BITS-1:0] bias_1,
  output logic [DATA_BITS-1:0] bias_2,
  output logic [6:0]           out_cnt,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 cfg_err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;

  conv2_state_t state_q, state_d;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_wrap;
  logic          row_last;

  logic accept;
  logic win_hit;
  logic frame_end;
  logic pos_clear;
  logic cfg_ok;
  logic cfg_bad;

  logic                 win_valid_q, win_valid_d;
  logic [6:0]           out_cnt_q, out_cnt_d;
  logic                 cfg_err_q, cfg_err_d;
  logic [BIAS_BITS-1:0] bias0_q, bias0_d;
  logic [BIAS_BITS-1:0] bias1_q, bias1_d;
  logic [BIAS_BITS-1:0] bias2_q, bias2_d;

  conv2_pos_cnt #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .CW     (CW),
    .RW     (RW)
  ) u_pos (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (pos_clear),
    .advance  (accept),
    .col      (col),
    .row      (row),
    .col_wrap (col_wrap),
    .row_last (row_last)
  );

  // Pixel acceptance and window detection; a window closes on the bottom-right pixel of a KxK patch.
  always_comb begin
    accept    = (state_q == RUN) && valid_in;
    win_hit   = accept && (row >= RW'(KSIZE - 1)) && (col >= CW'(KSIZE - 1));
    frame_end = accept && col_wrap && row_last;
    pos_clear = (state_q == IDLE) && start;
    cfg_ok    = cfg_we && (state_q == IDLE) && (32'(cfg_addr) < CHANNELS);
    cfg_bad   = cfg_we && !cfg_ok;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: start only arms from IDLE; DONE always lasts a single cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (frame_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy spans RUN, frame_done marks the DONE cycle (aligned with the last win_valid).
  always_comb begin
    busy       = (state_q == RUN);
    frame_done = (state_q == DONE);
  end

  // Datapath registers: window strobe, window count, sticky error and biases.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_valid_q <= 1'b0;
      out_cnt_q   <= '0;
      cfg_err_q   <= 1'b0;
      bias0_q     <= '0;
      bias1_q     <= '0;
      bias2_q     <= '0;
    end else begin
      win_valid_q <= win_valid_d;
      out_cnt_q   <= out_cnt_d;
      cfg_err_q   <= cfg_err_d;
      bias0_q     <= bias0_d;
      bias1_q     <= bias1_d;
      bias2_q     <= bias2_d;
    end
  end

  // Window count clears on start and holds its final value until the next start.
  always_comb begin
    win_valid_d = win_hit;
    out_cnt_d   = out_cnt_q;
    if (pos_clear) begin
      out_cnt_d = '0;
    end else if (win_hit) begin
      out_cnt_d = out_cnt_q + 7'd1;
    end
  end

  // Bias writes land only in IDLE so biases are frozen for a whole frame; anything else flags cfg_err.
  always_comb begin
    bias0_d   = bias0_q;
    bias1_d   = bias1_q;
    bias2_d   = bias2_q;
    cfg_err_d = cfg_err_q | cfg_bad;
    if (cfg_ok) begin
      case (cfg_addr)
        2'd0:    bias0_d = cfg_wdata;
        2'd1:    bias1_d = cfg_wdata;
        2'd2:    bias2_d = cfg_wdata;
        default: ;
      endcase
    end
  end

  // Output drive, biases sign-extended to the datapath width.
  always_comb begin
    win_valid = win_valid_q;
    out_cnt   = out_cnt_q;
    cfg_err   = cfg_err_q;
    bias_0    = DATA_BITS'(sext_bias(32'(bias0_q), BIAS_BITS));
    bias_1    = DATA_BITS'(sext_bias(32'(bias1_q), BIAS_BITS));
    bias_2    = DATA_BITS'(sext_bias(32'(bias2_q), BIAS_BITS));
  end

endmodule

// File: tb/tb_conv2_sched.sv
// tb/tb_conv2_sched.sv - self-checking bench for conv2_sched
module tb_conv2_sched;

  localparam int W     = 12;
  localparam int H     = 12;
  localparam int K     = 5;
  localparam int NPIX  = W * H;
  localparam int NWIN  = (W - K + 1) * (H - K + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        valid_in = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [7:0]  cfg_wdata = 8'd0;
  logic        win_valid;
  logic [11:0] bias_0, bias_1, bias_2;
  logic [6:0]  out_cnt;
  logic        busy;
  logic        frame_done;
  logic        cfg_err;

  int checks = 0;
  int failures = 0;

  logic [11:0] exp_b0 = '0, exp_b1 = '0, exp_b2 = '0;
  logic        exp_err = 1'b0;

  always #5 clk = ~clk;

  conv2_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .valid_in   (valid_in),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .win_valid  (win_valid),
    .bias_0     (bias_0),
    .bias_1     (bias_1),
    .bias_2     (bias_2),
    .out_cnt    (out_cnt),
    .busy       (busy),
    .frame_done (frame_done),
    .cfg_err    (cfg_err)
  );

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [7:0]  data;
    logic [11:0] b0;
    logic [11:0] b1;
    logic [11:0] b2;
    logic        err;
  } cfg_vec_t;

  cfg_vec_t tbl [11];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // A pixel at raster index idx completes a window when its row and column are both >= K-1.
  function automatic bit is_win(input int idx);
    return ((idx / W) >= K - 1) && ((idx % W) >= K - 1);
  endfunction

  task automatic model_reset;
    exp_b0  = '0;
    exp_b1  = '0;
    exp_b2  = '0;
    exp_err = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_win_valid"}, 32'(win_valid), 0);
    chk({tag, "_out_cnt"}, 32'(out_cnt), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_cfg_err"}, 32'(cfg_err), 0);
    chk({tag, "_bias_0"}, 32'(bias_0), 0);
    chk({tag, "_bias_1"}, 32'(bias_1), 0);
    chk({tag, "_bias_2"}, 32'(bias_2), 0);
  endtask

  task automatic chk_cfg(input string tag);
    chk({tag, "_bias_0"}, 32'(bias_0), 32'(exp_b0));
    chk({tag, "_bias_1"}, 32'(bias_1), 32'(exp_b1));
    chk({tag, "_bias_2"}, 32'(bias_2), 32'(exp_b2));
    chk({tag, "_cfg_err"}, 32'(cfg_err), 32'(exp_err));
  endtask

  task automatic apply_tbl(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      cfg_we    = tbl[i].we;
      cfg_addr  = tbl[i].addr;
      cfg_wdata = tbl[i].data;
      tick;
      cfg_we = 1'b0;
      chk($sformatf("tbl%0d_bias_0", i), 32'(bias_0), 32'(tbl[i].b0));
      chk($sformatf("tbl%0d_bias_1", i), 32'(bias_1), 32'(tbl[i].b1));
      chk($sformatf("tbl%0d_bias_2", i), 32'(bias_2), 32'(tbl[i].b2));
      chk($sformatf("tbl%0d_cfg_err", i), 32'(cfg_err), 32'(tbl[i].err));
      exp_b0  = tbl[i].b0;
      exp_b1  = tbl[i].b1;
      exp_b2  = tbl[i].b2;
      exp_err = tbl[i].err;
    end
  endtask

  task automatic noise_on(input bit noise);
    if (noise) begin
      start     = 1'($urandom_range(0, 1));
      cfg_we    = 1'($urandom_range(0, 1));
      cfg_addr  = 2'($urandom_range(0, 3));
      cfg_wdata = 8'($urandom);
      if (cfg_we) exp_err = 1'b1;
    end
  endtask

  task automatic noise_off;
    start  = 1'b0;
    cfg_we = 1'b0;
  endtask

  // Drive one frame: optional random gaps, optional start/cfg noise during RUN,
  // optional reset at a pixel index, optional start held during the DONE cycle.
  task automatic run_frame(input string tag, input int maxgap, input bit noise,
                           input int abort_at, input bit start_in_done);
    int acc;
    int cnt;
    int nwin;
    int first;
    int gap;
    bit w;
    bit last;
    acc   = 0;
    cnt   = 0;
    nwin  = 0;
    first = -1;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk({tag, "_busy_after_start"}, 32'(busy), 1);
    chk({tag, "_cnt_after_start"}, 32'(out_cnt), 0);
    while (acc < NPIX) begin
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      for (int g = 0; g < gap; g++) begin
        valid_in = 1'b0;
        noise_on(noise);
        tick;
        noise_off;
        chk({tag, "_gap_win"}, 32'(win_valid), 0);
        chk({tag, "_gap_done"}, 32'(frame_done), 0);
        chk({tag, "_gap_cnt"}, 32'(out_cnt), 32'(cnt));
        chk({tag, "_gap_busy"}, 32'(busy), 1);
      end
      if (acc == abort_at) begin
        rst_n    = 1'b0;
        valid_in = 1'b1;
        tick;
        rst_n = 1'b1;
        model_reset;
        chk_reset_state({tag, "_abort"});
        for (int j = 0; j < 6; j++) begin
          tick;
          chk({tag, "_post_abort_done"}, 32'(frame_done), 0);
          chk({tag, "_post_abort_win"}, 32'(win_valid), 0);
          chk({tag, "_post_abort_busy"}, 32'(busy), 0);
        end
        valid_in = 1'b0;
        return;
      end
      valid_in = 1'b1;
      noise_on(noise);
      tick;
      noise_off;
      valid_in = 1'b0;
      w    = is_win(acc);
      last = (acc == NPIX - 1);
      if (w) cnt++;
      chk($sformatf("%s_win_px%0d", tag, acc), 32'(win_valid), 32'(w));
      chk($sformatf("%s_done_px%0d", tag, acc), 32'(frame_done), 32'(last));
      chk($sformatf("%s_cnt_px%0d", tag, acc), 32'(out_cnt), 32'(cnt));
      chk($sformatf("%s_busy_px%0d", tag, acc), 32'(busy), 32'(!last));
      if (win_valid === 1'b1) begin
        nwin++;
        if (first < 0) first = acc;
      end
      acc++;
    end
    start = start_in_done;
    tick;
    start = 1'b0;
    chk({tag, "_idle_busy"}, 32'(busy), 0);
    chk({tag, "_idle_done"}, 32'(frame_done), 0);
    chk({tag, "_idle_win"}, 32'(win_valid), 0);
    chk({tag, "_idle_cnt"}, 32'(out_cnt), NWIN);
    chk({tag, "_npulses"}, 32'(nwin), NWIN);
    chk({tag, "_first_px"}, 32'(first), 52);
    chk_cfg({tag, "_cfg"});
  endtask

  initial begin
    tbl[0]  = '{1'b1, 2'd0, 8'h05, 12'h005, 12'h000, 12'h000, 1'b0};
    tbl[1]  = '{1'b1, 2'd1, 8'hF3, 12'h005, 12'hFF3, 12'h000, 1'b0};
    tbl[2]  = '{1'b1, 2'd2, 8'h80, 12'h005, 12'hFF3, 12'hF80, 1'b0};
    tbl[3]  = '{1'b0, 2'd3, 8'hAA, 12'h005, 12'hFF3, 12'hF80, 1'b0};
    tbl[4]  = '{1'b1, 2'd1, 8'h7F, 12'h005, 12'h07F, 12'hF80, 1'b0};
    tbl[5]  = '{1'b1, 2'd1, 8'hF3, 12'h005, 12'hFF3, 12'hF80, 1'b0};
    tbl[6]  = '{1'b1, 2'd0, 8'h7F, 12'h07F, 12'h000, 12'h000, 1'b0};
    tbl[7]  = '{1'b1, 2'd3, 8'h55, 12'h07F, 12'h000, 12'h000, 1'b1};
    tbl[8]  = '{1'b1, 2'd2, 8'h01, 12'h07F, 12'h000, 12'h001, 1'b1};
    tbl[9]  = '{1'b0, 2'd0, 8'h00, 12'h07F, 12'h000, 12'h001, 1'b1};
    tbl[10] = '{1'b1, 2'd3, 8'hFF, 12'h07F, 12'h000, 12'h001, 1'b1};

    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    model_reset;
    chk_reset_state("reset");

    apply_tbl(0, 6);

    run_frame("f_plain", 0, 1'b0, -1, 1'b0);

    // valid_in while IDLE must not disturb anything.
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1;
      tick;
      valid_in = 1'b0;
      chk("idle_valid_cnt", 32'(out_cnt), NWIN);
      chk("idle_valid_busy", 32'(busy), 0);
      chk("idle_valid_win", 32'(win_valid), 0);
    end

    run_frame("f_gap_noise", 3, 1'b1, -1, 1'b0);
    chk("run_write_err", 32'(cfg_err), 1);

    run_frame("f_abort", 2, 1'b0, 80, 1'b0);

    apply_tbl(6, 11);

    run_frame("f_gap", 3, 1'b0, -1, 1'b1);
    run_frame("f_b2b", 0, 1'b0, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
